subtractor_arbiter: RTL

SUBTRACTOR_ARBITER -- requirements
Module: subtractor_arbiter

---
 rtl/subtractor_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/subtractor_arbiter.sv
// subtractor_arbiter
//   Two requesters share one BITS-wide subtractor. A round-robin arbiter picks
//   one operand pair while idle. The pair is latched, and the magnitude |a-b|
//   is computed in one cycle. The result is held until the consumer takes it.
//   At most one operation is in flight, so results come back in acceptance order.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/reqN_a/reqN_b      requester N operand pair (N = 0, 1)
//   reqN_ready                    combinational grant, high only while idle
//   rsp_valid/rsp_ready           result handshake
//   rsp_id                        requester that owns the result
//   rsp_diff/rsp_neg              |a-b| and (a < b)
//   ops_done                      completed result handshakes, wraps at 16 bits

// Shared subtractor: the caller guarantees in1 >= in2.
module subtractor_core #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] in1,
    input  logic [BITS-1:0] in2,
    output logic [BITS-1:0] diff
);
    assign diff = in1 - in2;
endmodule

module subtractor_arbiter #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [BITS-1:0] req0_a,
    input  logic [BITS-1:0] req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [BITS-1:0] req1_a,
    input  logic [BITS-1:0] req1_b,
    output logic            req1_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [BITS-1:0] rsp_diff,
    output logic            rsp_neg,
    output logic [15:0]     ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic [BITS-1:0] a_r;
    logic [BITS-1:0] b_r;
    logic            id_r;
    logic            last_r;       // requester that owned the last completed result
    logic            rsp_valid_r;
    logic            rsp_id_r;
    logic [BITS-1:0] rsp_diff_r;
    logic            rsp_neg_r;
    logic [15:0]     ops_done_r;

    logic            grant_any_s;
    logic            grant_id_s;
    logic            idle_grant_s;
    logic            a_ge_b_s;
    logic [BITS-1:0] in1_s;
    logic [BITS-1:0] in2_s;
    logic [BITS-1:0] diff_s;

    // Round-robin pick: on a tie the requester not served last wins.
    // A lone valid requester wins regardless of the pointer.
    always_comb begin
        grant_any_s = 1'b0;
        grant_id_s  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_any_s = 1'b1;
            grant_id_s  = ~last_r;
        end else if (req0_valid) begin
            grant_any_s = 1'b1;
            grant_id_s  = 1'b0;
        end else if (req1_valid) begin
            grant_any_s = 1'b1;
            grant_id_s  = 1'b1;
        end else begin
            grant_any_s = 1'b0;
            grant_id_s  = 1'b0;
        end
    end

    // Grants are qualified with rst_n so ready stays low during reset.
    assign idle_grant_s = rst_n && (state_r == IDLE) && grant_any_s;
    assign req0_ready   = idle_grant_s && !grant_id_s;
    assign req1_ready   = idle_grant_s && grant_id_s;

    // Steer the larger operand to in1 so the subtractor sees in1 >= in2.
    always_comb begin
        a_ge_b_s = (a_r >= b_r);
        if (a_ge_b_s) begin
            in1_s = a_r;
            in2_s = b_r;
        end else begin
            in1_s = b_r;
            in2_s = a_r;
        end
    end

    subtractor_core #(.BITS(BITS)) u_sub (
        .in1  (in1_s),
        .in2  (in2_s),
        .diff (diff_s)
    );

    // Control FSM: it latches operands, registers the result and handles the response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            id_r        <= 1'b0;
            last_r      <= 1'b1;   // makes requester 0 win the first tie
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_diff_r  <= '0;
            rsp_neg_r   <= 1'b0;
            ops_done_r  <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (idle_grant_s) begin
                        a_r     <= grant_id_s ? req1_a : req0_a;
                        b_r     <= grant_id_s ? req1_b : req0_b;
                        id_r    <= grant_id_s;
                        state_r <= CALC;
                    end
                end
                CALC: begin
                    rsp_diff_r  <= diff_s;
                    rsp_neg_r   <= ~a_ge_b_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        last_r      <= rsp_id_r;
                        ops_done_r  <= ops_done_r + 16'd1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_diff  = rsp_diff_r;
    assign rsp_neg   = rsp_neg_r;
    assign ops_done  = ops_done_r;

endmodule
